// File: rtl/hack_rom_loader.sv
// Hack ROM port owner: muxes HPS .BIN download writes against CPU fetch and sequences CPU reset around loads.
// Fetch is combinational; each download write is registered once and commits next cycle with ioctl_wait high for that cycle. Optional HACK_LOADER_CKSUM_EN adds a running checksum.
module hack_rom_loader #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_we,
  output logic [DATA_W-1:0] rom_wdata,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              cpu_reset,
  output logic [15:0]       words_loaded,
  output logic              load_error,
  output logic [15:0]       checksum
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } pend_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic             dl_q;
  logic             pend_vld;
  pend_t            pend;

  logic dl_rise;
  logic strobe;
  logic wr_err;
  logic wr_take;
  logic load_start;
  logic unused_bits;

  assign unused_bits = ioctl_addr[0];

  assign dl_rise = ioctl_download & ~dl_q;

  // The strobe on the cycle download is first seen low is still part of the
  // transfer (state is still LOAD); any other strobe with download low is ignored.
  assign strobe  = ioctl_wr & (ioctl_download | (state == LOAD));
  assign wr_err  = strobe & (pend_vld | (|ioctl_addr[24:16]));
  assign wr_take = strobe & ~wr_err;

  assign load_start = (state_nxt == LOAD) && (state != LOAD);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = hold_cnt;
    case (state)
      HOLD: begin
        if (ioctl_download) begin
          state_nxt = LOAD;
        end else if (!pend_vld) begin
          // The trailing commit of a download finishes before the settle count starts.
          if (hold_cnt <= CNT_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = hold_cnt - CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (dl_rise) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_nxt = HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYCLES);
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = CNT_W'(HOLD_CYCLES);
      end
    endcase
  end

  always_comb begin
    rom_we      = pend_vld;
    ioctl_wait  = pend_vld;
    rom_wdata   = pend.dat;
    rom_addr    = pend_vld ? pend.addr : pc;
    cpu_reset   = (state != RUN);
    instruction = (state == RUN) ? rom_rdata : '0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= HOLD;
      hold_cnt <= CNT_W'(HOLD_CYCLES);
      dl_q     <= 1'b0;
      pend_vld <= 1'b0;
      pend     <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= cnt_nxt;
      dl_q     <= ioctl_download;
      pend_vld <= wr_take;
      if (wr_take) begin
        pend.addr <= ioctl_addr[ADDR_W:1];
        pend.dat  <= DATA_W'(ioctl_dout);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      words_loaded <= '0;
      load_error   <= 1'b0;
    end else begin
      if (load_start) begin
        words_loaded <= '0;
      end else if (pend_vld && (words_loaded != 16'hFFFF)) begin
        words_loaded <= words_loaded + 16'd1;
      end
      // A bad strobe in the entry cycle belongs to the new download, so it wins over the clear.
      if (wr_err) begin
        load_error <= 1'b1;
      end else if (load_start) begin
        load_error <= 1'b0;
      end
    end
  end

`ifdef HACK_LOADER_CKSUM_EN
  logic [15:0] cksum_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cksum_q <= '0;
    end else if (load_start) begin
      cksum_q <= '0;
    end else if (pend_vld) begin
      cksum_q <= cksum_q + 16'(pend.dat);
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader with a behavioural single-port ROM.
module tb_hack_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic [14:0] pc;
  logic [15:0] instruction;
  logic [14:0] rom_addr;
  logic        rom_we;
  logic [15:0] rom_wdata;
  logic [15:0] rom_rdata;
  logic        cpu_reset;
  logic [15:0] words_loaded;
  logic        load_error;
  logic [15:0] checksum;

  int total = 0;
  int bad   = 0;

  logic        mem_init;
  logic [15:0] mem [0:32767];

`ifdef HACK_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  always #5 clk_sys = ~clk_sys;

  hack_rom_loader #(.ADDR_W(15), .DATA_W(16), .HOLD_CYCLES(16)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .pc             (pc),
    .instruction    (instruction),
    .rom_addr       (rom_addr),
    .rom_we         (rom_we),
    .rom_wdata      (rom_wdata),
    .rom_rdata      (rom_rdata),
    .cpu_reset      (cpu_reset),
    .words_loaded   (words_loaded),
    .load_error     (load_error),
    .checksum       (checksum)
  );

  always @(posedge clk_sys) begin
    if (mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'h0000;
      mem[5] <= 16'hBEEF;
      mem[6] <= 16'h7777;
    end else if (rom_we) begin
      mem[rom_addr] <= rom_wdata;
    end
  end

  assign rom_rdata = mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ck(input logic [15:0] v);
    return CK ? v : 16'h0000;
  endfunction

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic wr_word(input logic [24:0] a, input logic [15:0] d);
    chk("wait_idle", ioctl_wait, 1'b0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
    chk("wait_pend", ioctl_wait, 1'b1);
    chk("we_pend", rom_we, 1'b1);
    chk("we_addr", rom_addr, a[15:1]);
    chk("we_data", rom_wdata, d);
    step();
  endtask

  initial begin
    mem_init       = 1'b1;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    pc             = 15'd5;
    repeat (3) step();
    mem_init = 1'b0;

    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_we", rom_we, 1'b0);
    chk("rst_words", words_loaded, 16'h0);
    chk("rst_err", load_error, 1'b0);
    chk("rst_cksum", checksum, 16'h0);
    chk("rst_instr", instruction, 16'h0);

    // Reset release: 16 cycles of cpu_reset, then fetch passes straight through.
    reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      chk("t1_cpu_reset", cpu_reset, (i < 16));
      if (i == 0) chk("t1_hold_instr", instruction, 16'h0);
      step();
    end
    chk("t1_instr", instruction, 16'hBEEF);
    chk("t1_rom_addr", rom_addr, 15'd5);
    pc = 15'd6;
    #1 chk("t1_instr_comb", instruction, 16'h7777);
    step();

    // Strobe with download low is ignored.
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h8;
    ioctl_dout = 16'hDEAD;
    #1 chk("ign_wait0", ioctl_wait, 1'b0);
    step();
    ioctl_wr = 1'b0;
    chk("ign_wait", ioctl_wait, 1'b0);
    chk("ign_we", rom_we, 1'b0);
    chk("ign_err", load_error, 1'b0);
    chk("ign_cpu_reset", cpu_reset, 1'b0);
    chk("ign_mem", mem[4], 16'h0);

    // Four words, two cycles apart.
    ioctl_download = 1'b1;
    step();
    chk("t2_cpu_reset", cpu_reset, 1'b1);
    chk("t2_instr", instruction, 16'h0);
    chk("t2_words0", words_loaded, 16'h0);
    wr_word(25'h0, 16'h1234);
    wr_word(25'h2, 16'h5678);
    wr_word(25'h4, 16'h9ABC);
    wr_word(25'h6, 16'hDEF0);
    chk("t2_words", words_loaded, 16'd4);
    chk("t2_err", load_error, 1'b0);
    chk("t2_cksum", checksum, ck(16'hE258));
    chk("t2_mem0", mem[0], 16'h1234);
    chk("t2_mem1", mem[1], 16'h5678);
    chk("t2_mem2", mem[2], 16'h9ABC);
    chk("t2_mem3", mem[3], 16'hDEF0);
    ioctl_download = 1'b0;
    for (int j = 0; j <= 17; j++) begin
      chk("t2_cpu_reset_end", cpu_reset, (j < 17));
      step();
    end
    pc = 15'd2;
    #1 chk("t2_run_instr", instruction, 16'h9ABC);
    chk("t2_words_held", words_loaded, 16'd4);

    // Back-to-back strobes: second dropped with error.
    ioctl_download = 1'b1;
    step();
    chk("t3_err0", load_error, 1'b0);
    chk("t3_words0", words_loaded, 16'h0);
    chk("t3_cksum0", checksum, 16'h0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h10;
    ioctl_dout = 16'hAAAA;
    step();
    ioctl_addr = 25'h12;
    ioctl_dout = 16'hBBBB;
    chk("t3_wait", ioctl_wait, 1'b1);
    chk("t3_addr", rom_addr, 15'd8);
    step();
    ioctl_wr = 1'b0;
    chk("t3_err", load_error, 1'b1);
    chk("t3_wait_clr", ioctl_wait, 1'b0);
    chk("t3_we_clr", rom_we, 1'b0);
    step();
    chk("t3_words", words_loaded, 16'd1);
    chk("t3_mem8", mem[8], 16'hAAAA);
    chk("t3_mem9", mem[9], 16'h0);

    // Out-of-range address, then error cleared by the next download.
    ioctl_download = 1'b0;
    step();
    ioctl_download = 1'b1;
    step();
    chk("t4_err_clr_a", load_error, 1'b0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h10000;
    ioctl_dout = 16'hCCCC;
    step();
    ioctl_wr = 1'b0;
    chk("t4_we", rom_we, 1'b0);
    chk("t4_wait", ioctl_wait, 1'b0);
    chk("t4_err", load_error, 1'b1);
    chk("t4_words", words_loaded, 16'h0);
    chk("t4_mem0", mem[0], 16'h1234);
    ioctl_download = 1'b0;
    step();
    ioctl_download = 1'b1;
    step();
    chk("t4_err_clr", load_error, 1'b0);

    // Checksum wrap.
    wr_word(25'h20, 16'h0001);
    chk("t6_cksum_a", checksum, ck(16'h0001));
    wr_word(25'h22, 16'hFFFF);
    chk("t6_cksum_wrap", checksum, 16'h0000);
    chk("t6_words", words_loaded, 16'd2);
    ioctl_download = 1'b0;
    repeat (18) step();
    chk("t6_run", cpu_reset, 1'b0);

    // Last strobe on the cycle download falls.
    ioctl_download = 1'b1;
    step();
    wr_word(25'h24, 16'h1234);
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h26;
    ioctl_dout     = 16'h1111;
    step();
    ioctl_wr = 1'b0;
    chk("t5_we", rom_we, 1'b1);
    chk("t5_addr", rom_addr, 15'h13);
    chk("t5_data", rom_wdata, 16'h1111);
    chk("t5_cpu_reset", cpu_reset, 1'b1);
    step();
    chk("t5_we_clr", rom_we, 1'b0);
    chk("t5_cksum", checksum, ck(16'h2345));
    chk("t5_words", words_loaded, 16'd2);
    chk("t5_mem", mem[15'h13], 16'h1111);
    for (int j = 0; j <= 16; j++) begin
      chk("t5_hold", cpu_reset, (j < 16));
      step();
    end
    pc = 15'h13;
    #1 chk("t5_instr", instruction, 16'h1111);

    // Async reset with a write pending: ROM keeps committed words only.
    ioctl_download = 1'b1;
    step();
    wr_word(25'h28, 16'h5A5A);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h2A;
    ioctl_dout = 16'h6B6B;
    step();
    ioctl_wr = 1'b0;
    chk("rm_wait", ioctl_wait, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rm_wait_clr", ioctl_wait, 1'b0);
    chk("rm_we", rom_we, 1'b0);
    chk("rm_cpu_reset", cpu_reset, 1'b1);
    chk("rm_words", words_loaded, 16'h0);
    chk("rm_instr", instruction, 16'h0);
    ioctl_download = 1'b0;
    step();
    chk("rm_mem_kept", mem[15'h14], 16'h5A5A);
    chk("rm_mem_dropped", mem[15'h15], 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
